// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   state_t       : sequencer state (CLEAR sweep, then READY for normal operation)
//   depth_f       : number of registers for a given address width
//   rd_addr_vec_t : widest packed read-address bus supported (MAX_READ ports)
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   localparam int unsigned MAX_READ       = 4;
   localparam int unsigned MAX_ADDR_WIDTH = 16;

   typedef logic [MAX_READ*MAX_ADDR_WIDTH-1:0] rd_addr_vec_t;

   function automatic int unsigned depth_f(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One synchronous read port of the register file.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   ready_i        : clear sweep finished; reads are ignored while low
//   rd_en_i        : read request for this port
//   rd_addr_i      : read address
//   mem_data_i     : current storage contents at rd_addr_i
//   wr_en_i/addr/data : write port, used for the same-cycle bypass
//   rd_data_o      : registered read data, holds when no read is accepted
//   rd_valid_o     : registered one-cycle valid flag
module regfile_rd_port #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 5,
   parameter int unsigned ZeroReg   = 1,
   parameter int unsigned Bypass    = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ready_i,
   input  logic                 rd_en_i,
   input  logic [AddrWidth-1:0] rd_addr_i,
   input  logic [DataWidth-1:0] mem_data_i,
   input  logic                 wr_en_i,
   input  logic [AddrWidth-1:0] wr_addr_i,
   input  logic [DataWidth-1:0] wr_data_i,
   output logic [DataWidth-1:0] rd_data_o,
   output logic                 rd_valid_o
);

   logic [DataWidth-1:0] rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (ready_i && rd_en_i) begin
         rd_valid_d = 1'b1;
         // Zero register wins over any in-flight write to address 0.
         if ((ZeroReg != 0) && (rd_addr_i == '0)) begin
            rd_data_d = '0;
         end else if ((Bypass != 0) && wr_en_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_d = wr_data_i;
         end else begin
            rd_data_d = mem_data_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, NUM_READ synchronous read ports.
// After reset a sequencer writes zero to every register before o_ready rises,
// so storage never holds X while still being free of a reset (RAM-inferable).
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_wr_en/i_wr_addr/i_wr_data : write port (accepted only while ready)
//   i_rd_en      : per-port read enable
//   i_rd_addr    : packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   o_rd_data    : packed registered read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_rd_valid   : per-port registered valid
//   o_ready      : clear sweep complete
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_READ   = 2,
   parameter int unsigned ZERO_REG   = 1,
   parameter int unsigned BYPASS     = 1
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_wr_en,
   input  logic [ADDR_WIDTH-1:0]            i_wr_addr,
   input  logic [DATA_WIDTH-1:0]            i_wr_data,
   input  logic [NUM_READ-1:0]              i_rd_en,
   input  logic [NUM_READ*ADDR_WIDTH-1:0]   i_rd_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0]   o_rd_data,
   output logic [NUM_READ-1:0]              o_rd_valid,
   output logic                             o_ready
);

   localparam int unsigned DEPTH = depth_f(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

   logic                  ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // State register and clear counter.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Next state: leave CLEAR on the edge that writes the last register.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) begin
               state_d = READY;
            end
         end
         READY: begin
            state_d = READY;
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   // Outputs: storage write source is the sweep in CLEAR, the write port in READY.
   always_comb begin
      ready     = (state_q == READY);
      mem_we    = 1'b0;
      mem_waddr = i_wr_addr;
      mem_wdata = i_wr_data;
      if (state_q == CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt_q;
         mem_wdata = '0;
      end else if (i_wr_en && !((ZERO_REG != 0) && (i_wr_addr == '0))) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign o_ready = ready;

   for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] rd_addr;
      logic [DATA_WIDTH-1:0] mem_rd;

      assign rd_addr = i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign mem_rd  = mem_q[rd_addr];

      regfile_rd_port #(
         .DataWidth (DATA_WIDTH),
         .AddrWidth (ADDR_WIDTH),
         .ZeroReg   (ZERO_REG),
         .Bypass    (BYPASS)
      ) u_rd_port (
         .clk_i      (i_clk),
         .rst_i      (i_rst),
         .ready_i    (ready),
         .rd_en_i    (i_rd_en[k]),
         .rd_addr_i  (rd_addr),
         .mem_data_i (mem_rd),
         .wr_en_i    (i_wr_en),
         .wr_addr_i  (i_wr_addr),
         .wr_data_i  (i_wr_data),
         .rd_data_o  (o_rd_data[k*DATA_WIDTH +: DATA_WIDTH]),
         .rd_valid_o (o_rd_valid[k])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. Two instances share the stimulus:
//   dut_a : defaults (ZERO_REG = 1, BYPASS = 1)
//   dut_b : ZERO_REG = 0, BYPASS = 0
module tb_regfile_mp;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;

   logic [63:0] rd_data_a, rd_data_b;
   logic [1:0]  rd_valid_a, rd_valid_b;
   logic        ready_a, ready_b;

   int errors = 0;
   int checks = 0;

   regfile_mp dut_a (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wr_en    (wr_en),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .i_rd_en    (rd_en),
      .i_rd_addr  (rd_addr),
      .o_rd_data  (rd_data_a),
      .o_rd_valid (rd_valid_a),
      .o_ready    (ready_a)
   );

   regfile_mp #(
      .ZERO_REG (0),
      .BYPASS   (0)
   ) dut_b (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wr_en    (wr_en),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .i_rd_en    (rd_en),
      .i_rd_addr  (rd_addr),
      .o_rd_data  (rd_data_b),
      .o_rd_valid (rd_valid_b),
      .o_ready    (ready_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_en   = 2'b00;
      rd_addr = '0;
   endtask

   // Reads addresses a0/a1 on ports 0/1 for one cycle.
   task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
      rd_en   = 2'b11;
      rd_addr = {a1, a0};
   endtask

   initial begin
      rst = 1'b1;
      idle();
      tick();
      tick();

      // Reset state
      check("rst_ready_a", 64'(ready_a), 64'd0);
      check("rst_valid_a", 64'(rd_valid_a), 64'd0);
      check("rst_data_a", rd_data_a, 64'd0);
      check("rst_ready_b", 64'(ready_b), 64'd0);

      // Clear sweep with write/read requests held active; all must be ignored.
      rst     = 1'b0;
      wr_en   = 1'b1;
      wr_addr = 5'd9;
      wr_data = 32'h77;
      rd_en   = 2'b11;
      rd_addr = {5'd9, 5'd9};
      for (int e = 1; e <= 32; e++) begin
         tick();
         check($sformatf("sweep_ready_a_e%0d", e), 64'(ready_a), (e == 32) ? 64'd1 : 64'd0);
         check($sformatf("sweep_ready_b_e%0d", e), 64'(ready_b), (e == 32) ? 64'd1 : 64'd0);
         check($sformatf("sweep_valid_a_e%0d", e), 64'(rd_valid_a), 64'd0);
         check($sformatf("sweep_valid_b_e%0d", e), 64'(rd_valid_b), 64'd0);
      end
      check("sweep_data_a", rd_data_a, 64'd0);
      idle();

      // Every address reads zero after the sweep (includes x9).
      for (int a = 0; a < 32; a++) begin
         rd2(5'(a), 5'(31 - a));
         tick();
         check($sformatf("clr_rd_a_%0d", a), rd_data_a, 64'd0);
         check($sformatf("clr_rd_b_%0d", a), rd_data_b, 64'd0);
         check($sformatf("clr_vld_a_%0d", a), 64'(rd_valid_a), 64'd3);
      end
      idle();

      // Write x5, then read it on both ports.
      wr_en   = 1'b1;
      wr_addr = 5'd5;
      wr_data = 32'hDEADBEEF;
      tick();
      idle();
      rd2(5'd5, 5'd5);
      tick();
      check("wr5_data_a", rd_data_a, 64'hDEADBEEF_DEADBEEF);
      check("wr5_data_b", rd_data_b, 64'hDEADBEEF_DEADBEEF);
      check("wr5_vld_a", 64'(rd_valid_a), 64'd3);
      check("wr5_vld_b", 64'(rd_valid_b), 64'd3);

      // Read enable low: data holds, valid drops.
      idle();
      tick();
      check("hold_data_a", rd_data_a, 64'hDEADBEEF_DEADBEEF);
      check("hold_vld_a", 64'(rd_valid_a), 64'd0);
      check("hold_data_b", rd_data_b, 64'hDEADBEEF_DEADBEEF);

      // Zero register
      wr_en   = 1'b1;
      wr_addr = 5'd0;
      wr_data = 32'h12345678;
      tick();
      idle();
      rd2(5'd0, 5'd0);
      tick();
      check("x0_a", rd_data_a, 64'd0);
      check("x0_b", rd_data_b, 64'h12345678_12345678);

      // Write to x0 in flight with a read of x0
      wr_en   = 1'b1;
      wr_addr = 5'd0;
      wr_data = 32'h99;
      rd2(5'd0, 5'd5);
      tick();
      check("x0_inflight_a", rd_data_a, 64'hDEADBEEF_00000000);
      check("x0_inflight_b", rd_data_b, 64'hDEADBEEF_12345678);
      idle();
      rd2(5'd0, 5'd0);
      tick();
      check("x0_after_b", rd_data_b, 64'h00000099_00000099);

      // Bypass: x7 = 1, then same-cycle write 0xAA / read x7.
      idle();
      wr_en   = 1'b1;
      wr_addr = 5'd7;
      wr_data = 32'h1;
      tick();
      wr_data = 32'hAA;
      rd2(5'd7, 5'd5);
      tick();
      check("byp_a", rd_data_a, 64'hDEADBEEF_000000AA);
      check("byp_b", rd_data_b, 64'hDEADBEEF_00000001);
      idle();
      rd2(5'd7, 5'd7);
      tick();
      check("byp_after_a", rd_data_a, 64'h000000AA_000000AA);
      check("byp_after_b", rd_data_b, 64'h000000AA_000000AA);

      // Mid-operation reset
      idle();
      wr_en   = 1'b1;
      wr_addr = 5'd3;
      wr_data = 32'h55;
      tick();
      idle();
      rd_en   = 2'b01;
      rd_addr = {5'd0, 5'd3};
      tick();
      check("x3_a", rd_data_a, 64'h000000AA_00000055);
      check("x3_vld_a", 64'(rd_valid_a), 64'd1);
      idle();
      rst = 1'b1;
      #1;
      check("arst_ready_a", 64'(ready_a), 64'd0);
      check("arst_vld_a", 64'(rd_valid_a), 64'd0);
      check("arst_data_a", rd_data_a, 64'd0);
      #1;
      rst = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         check($sformatf("part_ready_a_e%0d", e), 64'(ready_a), 64'd0);
      end
      // Asynchronous pulse in the middle of the cycle after edge 10.
      #2;
      rst = 1'b1;
      #1;
      check("arst2_ready_a", 64'(ready_a), 64'd0);
      check("arst2_vld_a", 64'(rd_valid_a), 64'd0);
      #1;
      rst = 1'b0;
      for (int e = 1; e <= 32; e++) begin
         tick();
         check($sformatf("resweep_ready_a_e%0d", e), 64'(ready_a), (e == 32) ? 64'd1 : 64'd0);
         check($sformatf("resweep_ready_b_e%0d", e), 64'(ready_b), (e == 32) ? 64'd1 : 64'd0);
      end
      rd2(5'd3, 5'd7);
      tick();
      check("x3_cleared_a", rd_data_a, 64'd0);
      check("x3_cleared_b", rd_data_b, 64'd0);
      check("x3_cleared_vld_a", 64'(rd_valid_a), 64'd3);
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the single-port negedge register file.
- One write port and NUM_READ independent synchronous read ports, each with its own valid flag.
- Optional hardwired zero register, optional write-to-read bypass, and a post-reset clear sequencer so storage never holds X.
- Sits in the core's decode/writeback path: read ports feed the operand stage, the write port is driven by writeback.

Parameters:
- DATA_WIDTH, 32: width of each register in bits.
- ADDR_WIDTH, 5: register address width; DEPTH = 2**ADDR_WIDTH.
- NUM_READ, 2: number of read ports (1 to 4).
- ZERO_REG, 1: 1 = address 0 always reads 0 and ignores writes.
- BYPASS, 1: 1 = a read of the address being written in the same cycle returns the new data; 0 = returns the old data.

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_wr_en  in  1  write enable.
- i_wr_addr  in  ADDR_WIDTH  write address.
- i_wr_data  in  DATA_WIDTH  write data.
- i_rd_en  in  NUM_READ  per-port read enable.
- i_rd_addr  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- o_rd_data  out  NUM_READ*DATA_WIDTH  packed read data, registered.
- o_rd_valid  out  NUM_READ  per-port read data valid, registered.
- o_ready  out  1  high once the clear sweep is complete; the block accepts reads and writes only while high.

Behaviour:
- Reset, asynchronous on i_rst high:
  - state = CLEAR, clear counter = 0.
  - o_ready = 0, o_rd_valid = 0, o_rd_data = 0.
  - Storage is not reset directly, so it stays RAM-inferable.
- FSM states:
  - CLEAR: each rising edge after i_rst falls writes 0 to register[counter], then counter increments.
  - CLEAR -> READY on the edge that writes register DEPTH-1. o_ready reads 1 after that edge, i.e. DEPTH edges after reset release (32 for defaults).
  - READY: normal operation. There is no exit except i_rst.
- While in CLEAR:
  - i_wr_en and i_rd_en are ignored.
  - o_rd_valid stays 0 and o_rd_data stays 0.
- i_rst asserted mid-CLEAR or in READY: immediate return to CLEAR with counter = 0; the sweep restarts in full.
- Write, READY only:
  - If i_wr_en is high, register[i_wr_addr] <= i_wr_data at the rising edge.
  - With ZERO_REG = 1, a write to address 0 is discarded.
- Read, READY only; latency 1 cycle, per port k:
  - If i_rd_en[k] is high at edge N: after edge N, o_rd_data[k] = the register value and o_rd_valid[k] = 1.
  - If i_rd_en[k] is low: o_rd_valid[k] = 0 and o_rd_data[k] holds its previous value.
- Zero register: ZERO_REG = 1 and address 0 -> read data 0, regardless of any write in flight.
- Same-cycle read/write of the same address, where the address is not the ZERO_REG case:
  - BYPASS = 1: the read returns i_wr_data.
  - BYPASS = 0: the read returns the pre-write contents.
- Multiple read ports on the same address are legal; all return identical data.
- Widths: no arithmetic; all addresses are full-range, with no out-of-range case.

Decomposition:
- Package regfile_pkg:
  - Enum state_t {CLEAR, READY}.
  - Localparam helper function for DEPTH.
  - Typedef for the packed address vector.
- Sub-module regfile_rd_port, instantiated NUM_READ times via generate:
  - Owns one port's output registers, zero-register masking and bypass mux.
  - Inputs: storage read value, write enable/address/data, ready.
- The top level holds the storage array, the clear counter and the FSM.

Test Plan:
- Clear sweep: release i_rst, sample every edge -> o_ready = 0 for edges 1..31 and 1 after edge 32; a read of every address then returns 0x00000000 with o_rd_valid = 1 one cycle after request.
- Write/read: write 0xDEADBEEF to x5, then next cycle read x5 on port 0 and x5 on port 1 -> both ports show 0xDEADBEEF with valid = 1 one cycle later.
- Zero register: write 0x12345678 to x0, then read x0 -> 0x00000000; repeat with ZERO_REG = 0 -> 0x12345678.
- Bypass: x7 holds 0x1, same-cycle write 0xAA to x7 and read x7 -> BYPASS = 1 returns 0xAA; BYPASS = 0 returns 0x1, then 0xAA on a following read.
- Mid-operation reset: write 0x55 to x3, pulse i_rst asynchronously mid-cycle during edge 10 of a new sweep -> o_ready drops immediately, o_rd_valid = 0, sweep restarts and takes 32 more edges; x3 then reads 0.
- Enable gating: in CLEAR assert i_wr_en to x9 = 0x77 and i_rd_en -> no valid pulses; after READY, x9 reads 0; with i_rd_en low in READY, o_rd_data holds its last value and valid = 0.
